// File: rtl/xgemac_lb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xgemac_lb_pkg
// Brief    : Shared types for the XGEMAC packet loopback engine.
// Revision : 1.0 - initial release
// ============================================================================
package xgemac_lb_pkg;

    localparam int LB_WORD_W = 69;

    typedef struct packed {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
    } lb_word_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rx_state_t;

    typedef enum logic [0:0] {
        T_IDLE = 1'b0,
        T_SEND = 1'b1
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/xgemac_lb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : xgemac_lb_fifo
// Brief    : Word FIFO of lb_word_t with a commit pointer; words beyond the
//            commit pointer are not yet releasable and can be rewound.
// Revision : 1.0 - initial release
// ============================================================================
module xgemac_lb_fifo
    import xgemac_lb_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  lb_word_t                 i_wr_word,
    input  logic                     i_rewind,
    input  logic                     i_commit,
    input  logic                     i_pop,
    output lb_word_t                 o_rd_word,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [$clog2(DEPTH):0]   o_avail
);

    localparam int c_AW = $clog2(DEPTH);

    lb_word_t          r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic [c_AW:0]     r_cmt_ptr;
    logic [c_AW:0]     w_base;
    logic [c_AW:0]     w_wr_nxt;

    // A rewind and a push in the same cycle restart the frame at the commit point.
    assign w_base   = i_rewind ? r_cmt_ptr : r_wr_ptr;
    assign w_wr_nxt = w_base + {{c_AW{1'b0}}, i_push};

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_base[c_AW-1:0]] <= i_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cmt_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            if (i_commit) begin
                r_cmt_ptr <= w_wr_nxt;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + {{c_AW{1'b0}}, 1'b1};
            end
        end
    end

    assign o_rd_word = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_avail   = r_cmt_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/xgemac_pkt_loopback.sv
`default_nettype none
// ============================================================================
// Module   : xgemac_pkt_loopback
// Brief    : Drains MAC RX frames into a word FIFO and replays them on MAC TX.
//            XGEMAC_LB_DROP_ERR_EN selects store-and-forward with error drop;
//            default build is cut-through.
// Revision : 1.0 - initial release
// ============================================================================
module xgemac_pkt_loopback
    import xgemac_lb_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 16
) (
    input  logic                          clk_156m25,
    input  logic                          reset_156m25,
    input  logic                          lb_enable,
    input  logic                          pkt_rx_avail,
    output logic                          pkt_rx_ren,
    input  logic                          pkt_rx_val,
    input  logic [63:0]                   pkt_rx_data,
    input  logic                          pkt_rx_sop,
    input  logic                          pkt_rx_eop,
    input  logic [2:0]                    pkt_rx_mod,
    input  logic                          pkt_rx_err,
    input  logic                          pkt_tx_full,
    output logic                          pkt_tx_val,
    output logic [63:0]                   pkt_tx_data,
    output logic                          pkt_tx_sop,
    output logic                          pkt_tx_eop,
    output logic [2:0]                    pkt_tx_mod,
    output logic [CNT_W-1:0]              rx_pkt_cnt,
    output logic [CNT_W-1:0]              tx_pkt_cnt,
    output logic [CNT_W-1:0]              drop_pkt_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    rx_state_t             r_rx_state, w_rx_state_nxt;
    tx_state_t             r_tx_state, w_tx_state_nxt;
    logic [c_LVL_W-1:0]    w_level, w_avail, w_free;
    logic                  w_free_ok, w_ren;
    lb_word_t              w_wr_word, w_rd_word;
    logic                  w_push, w_rewind, w_commit, w_pop, w_rx_done, w_drop;
    logic                  w_sop_mid;
    logic                  r_in_frame;
    logic                  r_tx_val, r_tx_sop, r_tx_eop;
    logic [63:0]           r_tx_data;
    logic [2:0]            r_tx_mod;
    logic [CNT_W-1:0]      r_rx_cnt, r_tx_cnt, r_drop_cnt;

    // Two free slots cover the word already in flight from the previous ren.
    assign w_free    = c_LVL_W'(FIFO_DEPTH) - w_level;
    assign w_free_ok = (w_free >= c_LVL_W'(2));

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_ren          = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                if (lb_enable && pkt_rx_avail && w_free_ok) begin
                    w_rx_state_nxt = R_READ;
                end
            end
            R_READ: begin
                w_ren = w_free_ok && !(pkt_rx_val && pkt_rx_eop);
                if (pkt_rx_val && pkt_rx_eop) begin
                    w_rx_state_nxt = R_IDLE;
                end
            end
            default: w_rx_state_nxt = R_IDLE;
        endcase
    end

    assign pkt_rx_ren = w_ren;
    assign w_wr_word  = '{data: pkt_rx_data, sop: pkt_rx_sop, eop: pkt_rx_eop, mod: pkt_rx_mod};
    assign w_sop_mid  = pkt_rx_val && pkt_rx_sop && r_in_frame;

`ifdef XGEMAC_LB_DROP_ERR_EN
    logic [c_LVL_W-1:0]    r_frame_len, w_frame_len_nxt, w_eff_len;
    logic                  r_discard, w_discard_nxt;

    assign w_eff_len = pkt_rx_sop ? '0 : r_frame_len;

    always_comb begin
        w_push          = 1'b0;
        w_rewind        = 1'b0;
        w_commit        = 1'b0;
        w_rx_done       = 1'b0;
        w_drop          = 1'b0;
        w_frame_len_nxt = r_frame_len;
        w_discard_nxt   = r_discard;
        if (pkt_rx_val) begin
            if (r_discard) begin
                w_discard_nxt = !pkt_rx_eop;
            end else if (pkt_rx_eop && pkt_rx_err) begin
                w_rewind        = 1'b1;
                w_drop          = 1'b1;
                w_frame_len_nxt = '0;
            end else if (w_eff_len == c_LVL_W'(FIFO_DEPTH - 2)) begin
                // Oversized frame can never commit; flush it and swallow the tail.
                w_rewind        = 1'b1;
                w_drop          = 1'b1;
                w_frame_len_nxt = '0;
                w_discard_nxt   = !pkt_rx_eop;
            end else begin
                w_push          = 1'b1;
                w_rewind        = w_sop_mid;
                w_drop          = w_sop_mid;
                w_commit        = pkt_rx_eop;
                w_rx_done       = pkt_rx_eop;
                w_frame_len_nxt = pkt_rx_eop ? '0 : w_eff_len + c_LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_frame_len <= '0;
            r_discard   <= 1'b0;
        end else begin
            r_frame_len <= w_frame_len_nxt;
            r_discard   <= w_discard_nxt;
        end
    end
`else
    logic w_unused_err;

    assign w_push       = pkt_rx_val;
    assign w_rewind     = 1'b0;
    assign w_commit     = pkt_rx_val;
    assign w_rx_done    = pkt_rx_val && pkt_rx_eop;
    assign w_drop       = w_sop_mid;
    assign w_unused_err = pkt_rx_err;
`endif

    xgemac_lb_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_156m25),
        .rst       (reset_156m25),
        .i_push    (w_push),
        .i_wr_word (w_wr_word),
        .i_rewind  (w_rewind),
        .i_commit  (w_commit),
        .i_pop     (w_pop),
        .o_rd_word (w_rd_word),
        .o_level   (w_level),
        .o_avail   (w_avail)
    );

    assign w_pop = (w_avail != '0) && !pkt_tx_full;

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            T_IDLE: if (w_pop && w_rd_word.sop && !w_rd_word.eop) w_tx_state_nxt = T_SEND;
            T_SEND: if (w_pop && w_rd_word.eop)                   w_tx_state_nxt = T_IDLE;
            default: w_tx_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            r_rx_state <= R_IDLE;
            r_tx_state <= T_IDLE;
            r_in_frame <= 1'b0;
            r_tx_val   <= 1'b0;
            r_tx_data  <= '0;
            r_tx_sop   <= 1'b0;
            r_tx_eop   <= 1'b0;
            r_tx_mod   <= '0;
            r_rx_cnt   <= '0;
            r_tx_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_tx_state <= w_tx_state_nxt;
            if (pkt_rx_val) begin
                r_in_frame <= !pkt_rx_eop;
            end
            r_tx_val   <= w_pop;
            r_tx_data  <= w_pop ? w_rd_word.data : '0;
            r_tx_sop   <= w_pop && w_rd_word.sop;
            r_tx_eop   <= w_pop && w_rd_word.eop;
            r_tx_mod   <= w_pop ? w_rd_word.mod : '0;
            r_rx_cnt   <= r_rx_cnt + CNT_W'(w_rx_done);
            r_tx_cnt   <= r_tx_cnt + CNT_W'(r_tx_val && r_tx_eop);
            r_drop_cnt <= r_drop_cnt + CNT_W'(w_drop);
        end
    end

    assign pkt_tx_val   = r_tx_val;
    assign pkt_tx_data  = r_tx_data;
    assign pkt_tx_sop   = r_tx_sop;
    assign pkt_tx_eop   = r_tx_eop;
    assign pkt_tx_mod   = r_tx_mod;
    assign rx_pkt_cnt   = r_rx_cnt;
    assign tx_pkt_cnt   = r_tx_cnt;
    assign drop_pkt_cnt = r_drop_cnt;
    assign fifo_level   = w_level;

endmodule
`default_nettype wire
